// File: rtl/trace_pkg.sv
// trace_pkg: shared entry, mode and state types for the retirement trace buffer
package trace_pkg;
    localparam int TRACE_XLEN = 32;

    typedef struct packed {
        logic [TRACE_XLEN-1:0] pc;
        logic [TRACE_XLEN-1:0] instruction;
        logic [TRACE_XLEN-1:0] alu_result;
        logic [TRACE_XLEN-1:0] write_data;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
    } trace_entry_t;

    typedef enum logic [1:0] {FREE = 2'd0, ONESHOT = 2'd1, TRIG = 2'd2} trace_mode_e;

    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} trace_state_e;
endpackage

// File: rtl/trace_ring_mem.sv
// trace_ring_mem: DEPTH x W register array, one write port and one asynchronous read port
module trace_ring_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 131
)(
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer: ring-buffer capture of retired instructions with free-run, one-shot and PC-trigger modes
module retire_trace_buffer
    import trace_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 16,
    parameter int POST_COUNT = 8
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    input  logic                       stop,
    input  logic [1:0]                 mode,
    input  logic [XLEN-1:0]            trig_pc,
    input  logic                       retire_valid,
    input  logic [XLEN-1:0]            pc,
    input  logic [XLEN-1:0]            instruction,
    input  logic [XLEN-1:0]            ALU_result,
    input  logic [XLEN-1:0]            write_data,
    input  logic                       RegWrite,
    input  logic                       MemRead,
    input  logic                       MemWrite,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [4*XLEN+2:0]          out_entry,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       triggered,
    output logic                       overflow,
    output logic                       done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(2 * DEPTH + 1);

    trace_state_e    state, state_n;
    trace_mode_e     mode_q;
    logic [XLEN-1:0] trig_q;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [PW-1:0]   post_cnt;
    logic            capturing, rec, hit, full, pop;

    assign capturing = state == ARMED || state == POST;
    assign rec       = capturing && retire_valid && !arm;
    assign hit       = state == ARMED && mode_q == TRIG && pc == trig_q;
    assign full      = count == CW'(DEPTH);
    assign done      = state == DONE;
    assign out_valid = done && count != '0;
    assign pop       = out_valid && out_ready;

    trace_ring_mem #(.DEPTH(DEPTH), .W(4 * XLEN + 3)) u_mem (
        .clk  (clk),
        .we   (rec && rst),
        .waddr(wr_ptr),
        .wdata({pc, instruction, ALU_result, write_data, RegWrite, MemRead, MemWrite}),
        .raddr(rd_ptr),
        .rdata(out_entry)
    );

    // stop outranks completion so a stopping retire is still recorded and ends capture
    always_comb begin
        state_n = state;
        if (arm) state_n = ARMED;
        else if (capturing && stop) state_n = DONE;
        else if (rec && hit) state_n = POST_COUNT == 0 ? DONE : POST;
        else if (rec && state == POST && post_cnt == PW'(1)) state_n = DONE;
        else if (rec && state == ARMED && mode_q == ONESHOT && count == CW'(DEPTH - 1)) state_n = DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            mode_q    <= FREE;
            trig_q    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
            triggered <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state <= state_n;
            if (arm) begin
                mode_q    <= mode == 2'd3 ? FREE : trace_mode_e'(mode);
                trig_q    <= trig_pc;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                post_cnt  <= '0;
                triggered <= 1'b0;
                overflow  <= 1'b0;
            end else begin
                if (rec) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (full) begin
                        rd_ptr   <= rd_ptr + 1'b1;
                        overflow <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                    if (hit) begin
                        triggered <= 1'b1;
                        post_cnt  <= PW'(POST_COUNT);
                    end else if (state == POST) begin
                        post_cnt <= post_cnt - 1'b1;
                    end
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    count  <= count - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb_retire_trace_buffer: directed plan plus random traffic checked against a queue-based reference model
module tb_retire_trace_buffer;
    import trace_pkg::*;

    localparam int XLEN       = 32;
    localparam int DEPTH      = 4;
    localparam int POST_COUNT = 2;
    localparam int EW         = 4 * XLEN + 3;
    localparam int P_IDLE = 0, P_ARMED = 1, P_POST = 2, P_DONE = 3;

    logic clk = 1'b0, rst = 1'b0, arm = 1'b0, stop = 1'b0, retire_valid = 1'b0, out_ready = 1'b0;
    logic RegWrite = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
    logic [1:0] mode = '0;
    logic [XLEN-1:0] trig_pc = '0, pc = '0, instruction = '0, ALU_result = '0, write_data = '0;
    logic out_valid, triggered, overflow, done;
    logic [EW-1:0] out_entry;
    logic [$clog2(DEPTH+1)-1:0] count;

    int n_assert = 0, n_fail = 0;

    logic [EW-1:0]   q[$];
    int              ph = P_IDLE, mm = 0, post = 0;
    logic [XLEN-1:0] mt = '0;
    bit              m_trg = 0, m_ovf = 0;

    always #5 clk = ~clk;

    retire_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_COUNT(POST_COUNT)) dut (
        .clk(clk), .rst(rst), .arm(arm), .stop(stop), .mode(mode), .trig_pc(trig_pc),
        .retire_valid(retire_valid), .pc(pc), .instruction(instruction), .ALU_result(ALU_result),
        .write_data(write_data), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .out_valid(out_valid), .out_ready(out_ready), .out_entry(out_entry), .count(count),
        .triggered(triggered), .overflow(overflow), .done(done)
    );

    function automatic logic [XLEN-1:0] pc_of(input logic [EW-1:0] x);
        trace_entry_t t;
        t = trace_entry_t'(x);
        return t.pc;
    endfunction

    task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock: drive, advance the model on the edge, then compare every observable output
    task automatic cyc(input bit a, input bit s, input logic [1:0] md, input logic [XLEN-1:0] tp,
                       input bit rv, input logic [XLEN-1:0] p, input bit rdy, input bit r = 1'b1);
        logic [EW-1:0] e;
        bit outv;
        int nxt;
        rst = r; arm = a; stop = s; mode = md; trig_pc = tp; retire_valid = rv; pc = p; out_ready = rdy;
        instruction = $urandom; ALU_result = $urandom; write_data = $urandom;
        {RegWrite, MemRead, MemWrite} = 3'($urandom);
        e = {pc, instruction, ALU_result, write_data, RegWrite, MemRead, MemWrite};
        outv = ph == P_DONE && q.size() != 0;
        @(posedge clk);
        nxt = ph;
        if (!r) begin
            nxt = P_IDLE; q.delete(); m_trg = 0; m_ovf = 0; post = 0;
        end else if (a) begin
            nxt = P_ARMED; mm = md == 2'd3 ? 0 : int'(md); mt = tp; q.delete(); m_trg = 0; m_ovf = 0; post = 0;
        end else if (ph == P_ARMED || ph == P_POST) begin
            if (rv) begin
                q.push_back(e);
                if (q.size() > DEPTH) begin
                    void'(q.pop_front());
                    m_ovf = 1;
                end
                if (ph == P_ARMED && mm == 2 && p == mt) begin
                    m_trg = 1; post = POST_COUNT; nxt = POST_COUNT == 0 ? P_DONE : P_POST;
                end else if (ph == P_POST) begin
                    post--;
                    if (post == 0) nxt = P_DONE;
                end else if (ph == P_ARMED && mm == 1 && q.size() == DEPTH) begin
                    nxt = P_DONE;
                end
            end
            if (s) nxt = P_DONE;
        end else if (outv && rdy) begin
            void'(q.pop_front());
        end
        ph = nxt;
        #1;
        chk("count", EW'(count), EW'(q.size()));
        chk("out_valid", EW'(out_valid), EW'(ph == P_DONE && q.size() != 0));
        chk("done", EW'(done), EW'(ph == P_DONE));
        chk("triggered", EW'(triggered), EW'(m_trg));
        chk("overflow", EW'(overflow), EW'(m_ovf));
        if (ph == P_DONE && q.size() != 0) chk("out_entry", out_entry, q[0]);
    endtask

    task automatic drain(input logic [XLEN-1:0] exp [4], input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            chk(tag, EW'(pc_of(out_entry)), EW'(exp[i]));
            cyc(0, 0, 2'd0, '0, 0, '0, 1);
        end
        chk({tag, "_empty"}, EW'(out_valid), '0);
    endtask

    initial begin
        logic [EW-1:0] hold;
        // reset held with retires present
        cyc(0, 0, 2'd0, '0, 1, 32'h100, 0, 0);
        cyc(0, 0, 2'd0, '0, 1, 32'h104, 0, 0);
        chk("rst_count", EW'(count), '0);
        chk("rst_done", EW'(done), '0);
        cyc(0, 0, 2'd0, '0, 0, '0, 0);

        // one-shot fills and stops accepting
        cyc(1, 0, 2'd1, '0, 0, '0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 2'd0, '0, 1, 32'(i * 4), 0);
        chk("t2_done", EW'(done), EW'(1));
        chk("t2_count", EW'(count), EW'(4));
        chk("t2_ovf", EW'(overflow), '0);
        drain('{32'h00, 32'h04, 32'h08, 32'h0C}, 4, "t2_rd");

        // free-run wrap keeps the newest entries
        cyc(1, 0, 2'd0, '0, 0, '0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 2'd0, '0, 1, 32'(i * 4), 0);
        cyc(0, 1, 2'd0, '0, 0, '0, 0);
        chk("t3_count", EW'(count), EW'(4));
        chk("t3_ovf", EW'(overflow), EW'(1));
        drain('{32'h0C, 32'h10, 32'h14, 32'h18}, 4, "t3_rd");

        // pc trigger with two post-trigger entries
        cyc(1, 0, 2'd2, 32'h20, 0, '0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 2'd0, '0, 1, 32'(32'h10 + i * 4), 0);
            if (i == 5) chk("t4_not_done_24", EW'(done), '0);
            if (i == 6) chk("t4_done_28", EW'(done), EW'(1));
        end
        chk("t4_trig", EW'(triggered), EW'(1));
        chk("t4_ovf", EW'(overflow), EW'(1));
        drain('{32'h1C, 32'h20, 32'h24, 32'h28}, 4, "t4_rd");

        // backpressure holds the head entry
        cyc(1, 0, 2'd1, '0, 0, '0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 2'd0, '0, 1, 32'(32'h50 + i * 4), 0);
        cyc(0, 0, 2'd0, '0, 0, '0, 1);
        hold = out_entry;
        cyc(0, 0, 2'd0, '0, 0, '0, 0);
        chk("t5_hold1", out_entry, hold);
        cyc(0, 0, 2'd0, '0, 0, '0, 1);
        hold = out_entry;
        cyc(0, 0, 2'd0, '0, 0, '0, 0);
        chk("t5_hold2", out_entry, hold);
        chk("t5_count", EW'(count), EW'(2));
        chk("t5_pc", EW'(pc_of(out_entry)), EW'(32'h58));

        // stop with a retire records that retire last
        cyc(1, 0, 2'd0, '0, 0, '0, 0);
        cyc(0, 0, 2'd0, '0, 1, 32'h30, 0);
        cyc(0, 1, 2'd0, '0, 1, 32'h40, 0);
        chk("t6_stop_done", EW'(done), EW'(1));
        drain('{32'h30, 32'h40, 32'h0, 32'h0}, 2, "t6_rd");

        // arm beats stop
        cyc(1, 1, 2'd0, '0, 0, '0, 0);
        chk("t6_armstop_done", EW'(done), '0);
        chk("t6_armstop_count", EW'(count), '0);
        cyc(0, 0, 2'd0, '0, 1, 32'h44, 0);
        chk("t6_armed_rec", EW'(count), EW'(1));

        // reset during readout
        cyc(0, 0, 2'd0, '0, 1, 32'h48, 0);
        cyc(0, 1, 2'd0, '0, 1, 32'h4C, 0);
        cyc(0, 0, 2'd0, '0, 0, '0, 1);
        cyc(0, 0, 2'd0, '0, 0, '0, 1, 0);
        chk("t6_rst_count", EW'(count), '0);
        chk("t6_rst_valid", EW'(out_valid), '0);
        cyc(0, 0, 2'd0, '0, 0, '0, 0);

        // random traffic
        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0, 2'($urandom),
                32'($urandom_range(0, 7) * 4), $urandom_range(0, 9) < 7,
                32'($urandom_range(0, 7) * 4), $urandom_range(0, 1) == 1, $urandom_range(0, 99) != 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/retire_trace_buffer.md
Name: retire_trace_buffer

Overview:
- Synthesizable retirement trace capture for the single-cycle RISC-V Processor; sits beside the core and samples the same debug outputs the bench prints each cycle.
- Replaces per-cycle $monitor dumps with a parametrised on-chip ring buffer.
- Three capture modes: free-run, one-shot, PC-triggered with post-trigger depth.
- Captured entries drain through a valid/ready port for bench or debug-link readout.

Parameters:
XLEN, 32, datapath width of pc/instruction/ALU_result/write_data
DEPTH, 16, entries stored; power of two, >=2
POST_COUNT, 8, entries recorded after the trigger entry in PC-trigger mode; 0..2*DEPTH legal

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; one clock, reset is synchronous and active-low (rst==0 at posedge resets)
arm  in  1  pulse; clear buffer and start capture
stop  in  1  pulse; end capture immediately
mode  in  2  0=FREE, 1=ONESHOT, 2=TRIG, 3=reserved (behaves as FREE); sampled when arm is accepted
trig_pc  in  XLEN  trigger address, sampled when arm is accepted
retire_valid  in  1  core retired an instruction this cycle
pc, instruction, ALU_result, write_data  in  XLEN each  retired-instruction fields
RegWrite, MemRead, MemWrite  in  1 each  retired control flags
out_valid  out  1  out_entry holds oldest unread entry
out_ready  in  1  consumer accepts out_entry
out_entry  out  4*XLEN+3  {pc, instruction, ALU_result, write_data, RegWrite, MemRead, MemWrite}
count  out  clog2(DEPTH+1)  entries held
triggered  out  1  sticky, trigger matched
overflow  out  1  sticky, at least one entry overwritten
done  out  1  state==DONE

Behaviour:
- Reset: state IDLE; wr_ptr, rd_ptr, count, post_cnt 0; triggered, overflow, done, out_valid 0. out_entry is don't-care until the first write.
- States: IDLE, ARMED, POST, DONE.
- arm (any state): next state ARMED. Latch mode/trig_pc. Clear pointers, count, triggered, overflow. arm wins over stop and retire in the same cycle; that cycle's retire is not recorded.
- Record rule (ARMED/POST): when retire_valid=1, write entry at wr_ptr and increment wr_ptr mod DEPTH.
  - If count<DEPTH, count+1.
  - If count==DEPTH, the oldest entry is dropped: rd_ptr+1 and overflow<=1.
  - Written data is visible the next cycle.
- ARMED, FREE: record until stop, then DONE.
- ARMED, ONESHOT: record; when a write makes count==DEPTH, go DONE next cycle. No overwrite ever occurs in ONESHOT.
- ARMED, TRIG: record every retire (pre-trigger history). On retire_valid and pc==trig_pc:
  - record that entry, set triggered=1, post_cnt<=POST_COUNT;
  - go POST, or DONE if POST_COUNT==0.
  - Further pc matches are ignored after the first.
- POST: each recorded retire decrements post_cnt; the write that brings it to 0 moves the block to DONE next cycle.
- stop in ARMED/POST: a retire in the same cycle is recorded first, then DONE. stop in IDLE/DONE is ignored.
- Readout (DONE only):
  - out_valid = (state==DONE) && count!=0; out_entry = mem[rd_ptr], combinational from registers.
  - On out_valid && out_ready: rd_ptr+1 mod DEPTH, count-1.
  - out_ready while out_valid=0 has no effect.
  - Retires in DONE/IDLE are ignored.
- Pointer wrap: both pointers wrap modulo DEPTH; full/empty is decided only by count.
- Reset mid-capture or mid-readout: immediate return to the reset state; buffer contents discarded.

Decomposition:
- Package trace_pkg holds:
  - typedef trace_entry_t (packed struct in the out_entry order);
  - enum trace_mode_e {FREE, ONESHOT, TRIG};
  - enum trace_state_e {IDLE, ARMED, POST, DONE}.
- One sub-module, trace_ring_mem: DEPTH x entry register array with write port (we, waddr, wdata) and async read (raddr, rdata). No reset on the array.
- Control FSM, pointers and counters stay in retire_trace_buffer.

Test Plan (DEPTH=4, POST_COUNT=2):
1. Reset: hold rst=0 for 2 cycles with retire_valid=1 -> count=0, out_valid=0, done=0, overflow=0; nothing recorded.
2. ONESHOT: arm, then retire pc=0x00,0x04,0x08,0x0C,0x10 on consecutive cycles -> done=1, count=4, overflow=0; readout with out_ready=1 gives pc 0x00,0x04,0x08,0x0C, then out_valid=0.
3. FREE wrap: arm, retire pc 0x00..0x18 step 4 (7 entries), then stop -> count=4, overflow=1; readout gives 0x0C,0x10,0x14,0x18.
4. TRIG: arm with trig_pc=0x20, retire 0x10,0x14,0x18,0x1C,0x20,0x24,0x28,0x2C -> done after 0x28, triggered=1, overflow=1; readout gives 0x1C,0x20,0x24,0x28; 0x2C is absent.
5. Backpressure: in DONE with count=4, toggle out_ready 1,0,1,0 -> exactly 2 pops; out_entry held stable while out_ready=0; count=2.
6. Simultaneous events:
   - stop with retire pc=0x40 in the same cycle -> 0x40 is the last entry.
   - arm and stop in the same cycle -> state ARMED, count=0.
   - rst=0 in the middle of readout -> count=0, out_valid=0 next cycle.
